// File: rtl/filter_pkg.sv
// Shared types and constants for the filter window controller: FSM states,
// the packed window descriptor, the reset window and the window legality rule.
package filter_pkg;

    localparam int FWC_GAMMA_CYCLE_WIDTH = 16;
    localparam int FWC_PW                = $clog2(FWC_GAMMA_CYCLE_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fwc_state_t;

    typedef struct packed {
        logic [FWC_PW-1:0] lo;
        logic [FWC_PW-1:0] hi;
    } win_cfg_t;

    // Widest window: opens one phase after grst and closes on the last phase.
    localparam win_cfg_t FWC_DEFAULT_WIN = '{
        lo: FWC_PW'(1),
        hi: FWC_PW'(FWC_GAMMA_CYCLE_WIDTH - 1)
    };

    // lo must stay clear of the grst phase and the window may not run past the gamma.
    function automatic logic win_cfg_legal(input win_cfg_t w);
        logic w_hi_ok;
        w_hi_ok = (FWC_GAMMA_CYCLE_WIDTH == (1 << FWC_PW)) ||
                  (int'(w.hi) < FWC_GAMMA_CYCLE_WIDTH);
        return (w.lo != '0) && (w.lo <= w.hi) && w_hi_ok;
    endfunction

endpackage

// File: rtl/win_cfg_buf.sv
// Double-buffered window register: legal windows are written straight into the
// active pair while idle, and parked in a shadow until the next gamma boundary while running.
module win_cfg_buf
    import filter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_run,
    input  logic     i_boundary,
    input  logic     i_cfg_valid,
    input  win_cfg_t i_cfg,
    output logic     o_cfg_ready,
    output logic     o_cfg_err,
    output win_cfg_t o_active
);

    win_cfg_t r_active;
    win_cfg_t r_shadow;
    logic     r_shd_vld;
    logic     r_cfg_err;

    logic     w_accept;
    logic     w_legal;
    logic     w_load_shadow;
    logic     w_load_direct;
    logic     w_drain;

    assign o_cfg_ready   = !i_run || !r_shd_vld;
    assign w_accept      = i_cfg_valid && o_cfg_ready;
    assign w_legal       = win_cfg_legal(i_cfg);
    assign w_load_shadow = w_accept && w_legal && i_run;
    assign w_load_direct = w_accept && w_legal && !i_run;

    // A parked window drains on a gamma boundary, or at once if sequencing stopped
    // on the same boundary that accepted it.
    assign w_drain = r_shd_vld && (i_boundary || !i_run);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= FWC_DEFAULT_WIN;
            r_shd_vld <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_legal;

            if (w_load_direct) begin
                r_active <= i_cfg;
            end else if (w_drain) begin
                r_active <= r_shadow;
            end

            if (w_load_shadow) begin
                r_shd_vld <= 1'b1;
            end else if (w_drain) begin
                r_shd_vld <= 1'b0;
            end
        end
    end

    // NOTE: the shadow data has no reset; it is only ever read while r_shd_vld is set.
    always_ff @(posedge clk) begin
        if (w_load_shadow) begin
            r_shadow <= i_cfg;
        end
    end

    assign o_cfg_err = r_cfg_err;
    assign o_active  = r_active;

endmodule

// File: rtl/filter_window_ctrl.sv
// Gamma sequencer for rising-edge filters sharing one window: frames gammas with
// grst, steps sel_greater/sel_lesser at the active lo/hi phases, counts gammas.
module filter_window_ctrl
    import filter_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = FWC_GAMMA_CYCLE_WIDTH,
    parameter int PW                = $clog2(GAMMA_CYCLE_WIDTH),
    parameter int CNT_W             = 16
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [PW-1:0]    cfg_lo,
    input  logic [PW-1:0]    cfg_hi,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             grst,
    output logic             sel_greater,
    output logic             sel_lesser,
    output logic             gamma_done,
    output logic             busy,
    output logic [CNT_W-1:0] gamma_cnt
);

    localparam logic [PW-1:0] PH_LAST = PW'(GAMMA_CYCLE_WIDTH - 1);

    fwc_state_t       r_state;
    fwc_state_t       w_state_nxt;
    logic [PW-1:0]    r_ph;
    logic             r_stop_pend;
    logic [CNT_W-1:0] r_gamma_cnt;

    logic             w_run;
    logic             w_boundary;
    win_cfg_t         w_cfg_in;
    win_cfg_t         w_active;

    assign w_run      = (r_state == RUN);
    assign w_boundary = w_run && (r_ph == PH_LAST);
    assign w_cfg_in   = '{lo: cfg_lo, hi: cfg_hi};

    win_cfg_buf u_win_cfg_buf (
        .clk         (aclk),
        .rst         (rst),
        .i_run       (w_run),
        .i_boundary  (w_boundary),
        .i_cfg_valid (cfg_valid),
        .i_cfg       (w_cfg_in),
        .o_cfg_ready (cfg_ready),
        .o_cfg_err   (cfg_err),
        .o_active    (w_active)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN:  if (w_boundary && r_stop_pend && !start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grst        = 1'b1;
        sel_greater = 1'b0;
        sel_lesser  = 1'b0;
        gamma_done  = 1'b0;
        busy        = 1'b0;
        if (w_run) begin
            grst        = (r_ph == '0);
            sel_greater = (r_ph >= w_active.lo);
            sel_lesser  = (r_ph >= w_active.hi);
            gamma_done  = (r_ph == PH_LAST);
            busy        = 1'b1;
        end
    end

    // Phase sits at 0 whenever idle, so entering RUN always begins a fresh gamma.
    always_ff @(posedge aclk) begin
        if (rst) begin
            r_ph        <= '0;
            r_stop_pend <= 1'b0;
            r_gamma_cnt <= '0;
        end else begin
            if (w_run && !w_boundary) begin
                r_ph <= r_ph + PW'(1);
            end else begin
                r_ph <= '0;
            end

            // start cancels a pending stop, even when both land in one cycle.
            if (!w_run || start) begin
                r_stop_pend <= 1'b0;
            end else if (w_boundary && r_stop_pend) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end

            if (w_boundary) begin
                r_gamma_cnt <= r_gamma_cnt + CNT_W'(1);
            end
        end
    end

    assign gamma_cnt = r_gamma_cnt;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Self-checking bench for filter_window_ctrl: a gamma-level reference model checked
// every cycle, plus directed scenarios with hand-computed window edge phases.
module tb_filter_window_ctrl;

    localparam int G  = 16;
    localparam int PW = 4;
    localparam int CW = 16;

    logic          aclk      = 1'b0;
    logic          rst       = 1'b1;
    logic          start     = 1'b0;
    logic          stop      = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [PW-1:0] cfg_lo    = '0;
    logic [PW-1:0] cfg_hi    = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic          grst;
    logic          sel_greater;
    logic          sel_lesser;
    logic          gamma_done;
    logic          busy;
    logic [CW-1:0] gamma_cnt;

    always #5 aclk = ~aclk;

    filter_window_ctrl #(
        .GAMMA_CYCLE_WIDTH (G),
        .PW                (PW),
        .CNT_W             (CW)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_lo      (cfg_lo),
        .cfg_hi      (cfg_hi),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .grst        (grst),
        .sel_greater (sel_greater),
        .sel_lesser  (sel_lesser),
        .gamma_done  (gamma_done),
        .busy        (busy),
        .gamma_cnt   (gamma_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one gamma at a time ----------------
    typedef struct {
        int lo;
        int hi;
    } win_t;

    bit   m_run      = 1'b0;
    int   m_t        = 0;
    win_t m_win      = '{1, G - 1};
    win_t m_pend[$];
    bit   m_stop_req = 1'b0;
    int   m_cnt      = 0;
    bit   m_err      = 1'b0;

    function automatic bit m_ready();
        return !m_run || (m_pend.size() == 0);
    endfunction

    always @(posedge aclk) begin : model
        win_t c;
        bit   acc;
        bit   legal;
        bit   eog;
        c.lo = int'(cfg_lo);
        c.hi = int'(cfg_hi);
        if (rst) begin
            m_run      = 1'b0;
            m_t        = 0;
            m_win      = '{1, G - 1};
            m_pend.delete();
            m_stop_req = 1'b0;
            m_cnt      = 0;
            m_err      = 1'b0;
        end else begin
            acc   = cfg_valid && m_ready();
            legal = (c.lo >= 1) && (c.lo <= c.hi) && (c.hi <= G - 1);
            m_err = acc && !legal;
            if (!m_run) begin
                if (acc && legal) begin
                    m_win = c;
                    m_pend.delete();
                end else if (m_pend.size() > 0) begin
                    m_win = m_pend.pop_front();
                end
                m_stop_req = 1'b0;
                if (start) begin
                    m_run = 1'b1;
                    m_t   = 0;
                end
            end else begin
                eog = (m_t == G - 1);
                if (eog) begin
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    if (m_pend.size() > 0) m_win = m_pend.pop_front();
                    m_t = 0;
                    if (m_stop_req && !start) m_run = 1'b0;
                end else begin
                    m_t++;
                end
                if (start)                 m_stop_req = 1'b0;
                else if (eog && m_stop_req) m_stop_req = 1'b0;
                else if (stop)             m_stop_req = 1'b1;
                if (acc && legal) m_pend.push_back(c);
            end
        end
    end

    always @(negedge aclk) begin
        if (cmp_en) begin
            check("grst",        int'(grst),        int'(!m_run || (m_t == 0)));
            check("sel_greater", int'(sel_greater), int'(m_run && (m_t >= m_win.lo)));
            check("sel_lesser",  int'(sel_lesser),  int'(m_run && (m_t >= m_win.hi)));
            check("gamma_done",  int'(gamma_done),  int'(m_run && (m_t == G - 1)));
            check("busy",        int'(busy),        int'(m_run));
            check("cfg_ready",   int'(cfg_ready),   int'(m_ready()));
            check("cfg_err",     int'(cfg_err),     int'(m_err));
            check("gamma_cnt",   int'(gamma_cnt),   m_cnt);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    int rg[4];
    int rl[4];
    int grst_hits[4];
    int done_ph[4];
    bit rdy0[4];
    bit lane_pass[4];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_cfg(input int lo, input int hi);
        cfg_valid = 1'b1;
        cfg_lo    = PW'(lo);
        cfg_hi    = PW'(hi);
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    // Observe n cycles from a known phase; records window edge phases per gamma and
    // the outcome of a rising-edge filter with input edges at ph3/4/9/10 in gamma 0.
    task automatic track(input int start_ph, input int n);
        int   p;
        int   g;
        logic psg;
        logic psl;
        for (int k = 0; k < 4; k++) begin
            rg[k] = -1; rl[k] = -1; grst_hits[k] = 0; done_ph[k] = -1;
            rdy0[k] = 1'b0; lane_pass[k] = 1'b0;
        end
        p   = start_ph;
        g   = 0;
        psg = sel_greater;
        psl = sel_lesser;
        for (int i = 0; i < n; i++) begin
            if (p == 0) begin
                psg = 1'b0;
                psl = 1'b0;
                rdy0[g] = cfg_ready;
            end
            if (sel_greater && !psg && rg[g] < 0) rg[g] = p;
            if (sel_lesser  && !psl && rl[g] < 0) rl[g] = p;
            if (grst)       grst_hits[g]++;
            if (gamma_done) done_ph[g] = p;
            if (g == 0) begin
                if (p == 3)  lane_pass[0] = sel_greater && !psl;
                if (p == 4)  lane_pass[1] = sel_greater && !psl;
                if (p == 9)  lane_pass[2] = sel_greater && !psl;
                if (p == 10) lane_pass[3] = sel_greater && !psl;
            end
            psg = sel_greater;
            psl = sel_lesser;
            tick(1);
            p++;
            if (p == G) begin
                p = 0;
                g++;
            end
        end
    endtask

    initial begin
        // Reset and idle.
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        check("idle_grst",      int'(grst),        1);
        check("idle_sel_g",     int'(sel_greater), 0);
        check("idle_sel_l",     int'(sel_lesser),  0);
        check("idle_busy",      int'(busy),        0);
        check("idle_cfg_ready", int'(cfg_ready),   1);
        check("idle_gamma_cnt", int'(gamma_cnt),   0);

        // Window 4/9 written while idle, then three gammas.
        send_cfg(4, 9);
        pulse_start();
        track(0, 48);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("g%0d_rise_greater", k), rg[k], 4);
            check($sformatf("g%0d_rise_lesser", k),  rl[k], 9);
            check($sformatf("g%0d_grst_hits", k),    grst_hits[k], 1);
            check($sformatf("g%0d_done_phase", k),   done_ph[k], 15);
        end
        check("lane_ph3",  int'(lane_pass[0]), 0);
        check("lane_ph4",  int'(lane_pass[1]), 1);
        check("lane_ph9",  int'(lane_pass[2]), 1);
        check("lane_ph10", int'(lane_pass[3]), 0);
        check("cnt_after_3", int'(gamma_cnt), 3);

        // Window 2/5 offered at ph7: parked until the boundary.
        tick(7);
        send_cfg(2, 5);
        check("ready_while_parked", int'(cfg_ready), 0);
        track(8, 24);
        check("cur_gamma_lesser", rl[0], 9);
        check("new_rise_greater", rg[1], 2);
        check("new_rise_lesser",  rl[1], 5);
        check("ready_at_ph0",     int'(rdy0[1]), 1);

        // Illegal windows are handshaken, flagged and dropped.
        send_cfg(0, 3);
        check("err_lo_zero", int'(cfg_err), 1);
        send_cfg(8, 6);
        check("err_lo_gt_hi", int'(cfg_err), 1);
        tick(1);
        check("err_cleared", int'(cfg_err), 0);
        track(3, 29);
        check("keep_rise_greater", rg[1], 2);
        check("keep_rise_lesser",  rl[1], 5);

        // stop at ph5 finishes the gamma then idles.
        tick(5);
        pulse_stop();
        tick(9);
        check("stop_last_busy", int'(busy),       1);
        check("stop_last_done", int'(gamma_done), 1);
        tick(1);
        check("stopped_busy", int'(busy),      0);
        check("stopped_grst", int'(grst),      1);
        check("stopped_cnt",  int'(gamma_cnt), 8);
        tick(3);
        check("idle_after_stop", int'(busy), 0);

        // stop then start inside one gamma: sequencing continues.
        pulse_start();
        tick(3);
        pulse_stop();
        tick(2);
        pulse_start();
        tick(9);
        check("cancel_busy", int'(busy),      1);
        check("cancel_grst", int'(grst),      1);
        check("cancel_cnt",  int'(gamma_cnt), 9);

        // Reset at ph8 with a parked window: default window, nothing pending.
        tick(3);
        send_cfg(6, 12);
        check("ready_parked_pre_rst", int'(cfg_ready), 0);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_busy",  int'(busy),      0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_cnt",   int'(gamma_cnt), 0);
        pulse_start();
        track(0, 32);
        check("dflt_rise_greater_0", rg[0], 1);
        check("dflt_rise_lesser_0",  rl[0], 15);
        check("dflt_rise_greater_1", rg[1], 1);
        check("dflt_rise_lesser_1",  rl[1], 15);

        // One-phase window 7/7 accepted on the boundary cycle itself.
        tick(15);
        send_cfg(7, 7);
        track(0, 32);
        check("bnd_keep_greater", rg[0], 1);
        check("bnd_keep_lesser",  rl[0], 15);
        check("one_ph_greater",   rg[1], 7);
        check("one_ph_lesser",    rl[1], 7);

        @(negedge aclk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
